iddmm_result_sel: RTL and testbench
===================================

Name: iddmm_result_sel

Overview:
- Final stage of the IDDMM Montgomery multiplier. Sits directly downstream of the iteration datapath.
- Captures the N-word candidate result A and the N-word difference A−P, both streamed out on the last outer iteration.
- Latches the final borrow sign and chooses A if A<P, otherwise A−P.
- Streams the chosen N words out LSW-first over a valid/ready interface to the exponentiation controller.

Parameters:
- K, 128, bits per word.
- N, 32, words per operand.
- ADDR_W, $clog2(N), word index width.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  synchronous active-high reset.
- fifo_wr_en_a  in  1  A word valid; words arrive LSW-first, exactly N per operation.
- fifo_wr_data_a  in  K  A word.
- fifo_wr_en_sub  in  1  A−P word valid; N per operation, LSW-first, ≥2 cycles behind matching A word.
- fifo_wr_data_sub  in  K  A−P word.
- cal_done  in  1  1-cycle pulse: last iteration entered final stage.
- cal_sign  in  1  borrow of A−P; meaningful on the cycle of the N-th fifo_wr_en_sub.
- o_valid  out  1  output word valid.
- o_ready  in  1  consumer accepts word when o_valid&&o_ready.
- o_data  out  K  selected result word.
- o_addr  out  ADDR_W  word index of o_data.
- o_last  out  1  high with word N−1.
- o_busy  out  1  high from first input beat until last output handshake.
- o_err  out  1  sticky protocol error flag.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, all counters 0, sel 0, done_seen 0, every output 0. Buffer contents are don't-care. Reset mid-operation aborts cleanly; no partial output is ever resumed.
- Storage: two N×K register arrays, buf_a and buf_s. Write pointers a_cnt and s_cnt are ADDR_W+1 bits and increment on each write enable.
- IDDMM_IDLE → IDDMM_COLLECT on first fifo_wr_en_a (word is stored that cycle).
- IDDMM_COLLECT:
  - Stores A and sub beats independently; both may occur in the same cycle.
  - Sets done_seen on cal_done.
  - On the N-th sub beat, latches sel=cal_sign (1 → output A, 0 → output A−P).
- COLLECT → IDDMM_OUTPUT at the edge after a_cnt==N, s_cnt==N and done_seen are all true. Entering OUTPUT resets rd_ptr=0.
- IDDMM_OUTPUT:
  - o_valid=1.
  - o_data = sel ? buf_a[rd_ptr] : buf_s[rd_ptr]. This is a combinational mux from registered storage; no extra latency.
  - o_addr=rd_ptr; o_last=(rd_ptr==N−1).
  - On handshake, rd_ptr increments.
  - Handshake with o_last → IDLE; counters, sel and done_seen cleared.
  - o_data, o_addr and o_last are held stable while o_valid&&!o_ready.
- Latency: first o_valid is 1 cycle after the edge at which the last of {N-th A beat, N-th sub beat, cal_done} is registered. Throughput is 1 word/cycle with o_ready=1.
- o_busy=1 in COLLECT and OUTPUT; 0 in IDLE.
- Errors set o_err (sticky until rst); the offending beat is dropped and state is unaffected:
  - A or sub beat when the respective count already equals N.
  - Any input beat during OUTPUT.
  - Sub beat in IDLE.
  - cal_done while done_seen=1.
- Pointer rules: no wrap-around. Counters saturate at N; rd_ptr wraps only via the return to IDLE.

Decomposition:
- Shared package iddmm_pkg holds:
  - enum iddmm_sel_state_t {IDDMM_IDLE, IDDMM_COLLECT, IDDMM_OUTPUT}.
  - Localparam defaults IDDMM_K=128, IDDMM_N=32.
- One natural sub-module, iddmm_word_buf: N×K register array with write pointer, count and full flag. Instantiated twice (A, sub); read index is supplied externally.

Test Plan (override K=8, N=4):
- A=[0x11,0x22,0x33,0x44], sub=[0xA0,0xA1,0xA2,0xA3] 2 cycles behind, cal_sign=1 on 4th sub, cal_done on 3rd sub cycle, o_ready=1 → o_data 0x11,0x22,0x33,0x44, o_addr 0..3, o_last on 4th, o_busy falls next cycle, o_err=0.
- Same stimulus with cal_sign=0 → outputs 0xA0..0xA3.
- o_ready toggling 1,0,0,1,0,1,1 → each word held while stalled; exactly 4 handshakes in order; no duplication.
- 5th A beat before output, plus one A beat during OUTPUT → o_err=1; output still the first 4 stored words.
- rst asserted after 2 A beats and 1 sub beat → next cycle all outputs 0. A fresh full operation then completes correctly with o_err=0.
- Back-to-back operations: second A stream starts the cycle after o_last handshake → second result correct, no mixing of words.

Source files
------------

// File: rtl/iddmm_pkg.sv
// Shared types and defaults for the IDDMM result-select stage.
package iddmm_pkg;

    localparam int IDDMM_K = 128;
    localparam int IDDMM_N = 32;

    typedef enum logic [1:0] {
        IDDMM_IDLE    = 2'd0,
        IDDMM_COLLECT = 2'd1,
        IDDMM_OUTPUT  = 2'd2
    } iddmm_sel_state_t;

endpackage

// File: rtl/iddmm_word_buf.sv
// N x K word store with saturating write count; read index is external.
module iddmm_word_buf
    import iddmm_pkg::*;
#(
    parameter int K  = IDDMM_K,
    parameter int N  = IDDMM_N,
    parameter int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [K-1:0]  wr_data,
    input  logic [AW-1:0] rd_idx,
    output logic [K-1:0]  rd_data,
    output logic [AW:0]   cnt,
    output logic          full
);

    logic [K-1:0] mem [N];
    logic         wr_ok;

    assign full    = (cnt == (AW+1)'(N));
    assign wr_ok   = wr_en && !full;
    assign rd_data = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (wr_ok) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Storage is deliberately not reset; stale words are never read.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[cnt[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/iddmm_result_sel.sv
// Final IDDMM stage: buffers A and A-P, picks one by borrow, streams it out.
module iddmm_result_sel
    import iddmm_pkg::*;
#(
    parameter int K      = IDDMM_K,
    parameter int N      = IDDMM_N,
    parameter int ADDR_W = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_wr_en_a,
    input  logic [K-1:0]      fifo_wr_data_a,
    input  logic              fifo_wr_en_sub,
    input  logic [K-1:0]      fifo_wr_data_sub,
    input  logic              cal_done,
    input  logic              cal_sign,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [K-1:0]      o_data,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last,
    output logic              o_busy,
    output logic              o_err
);

    iddmm_sel_state_t    state;
    logic [ADDR_W-1:0]   rd_ptr;
    logic                sel;
    logic                done_seen;
    logic [ADDR_W:0]     a_cnt, s_cnt;
    logic                a_full, s_full;
    logic [K-1:0]        a_rd, s_rd;
    logic                in_idle, in_coll, in_out;
    logic                a_wr, s_wr;
    logic                last_w, hs, fin, err_hit;

    assign in_idle = (state == IDDMM_IDLE);
    assign in_coll = (state == IDDMM_COLLECT);
    assign in_out  = (state == IDDMM_OUTPUT);

    assign a_wr   = fifo_wr_en_a && !in_out && !a_full;
    assign s_wr   = fifo_wr_en_sub && in_coll && !s_full;
    assign last_w = (rd_ptr == ADDR_W'(N - 1));
    assign hs     = in_out && o_ready;
    assign fin    = hs && last_w;

    assign err_hit = (fifo_wr_en_a && (a_full || in_out))
                  || (fifo_wr_en_sub && (s_full || !in_coll))
                  || (cal_done && done_seen);

    iddmm_word_buf #(.K(K), .N(N), .AW(ADDR_W)) u_buf_a (
        .clk     (clk),
        .rst     (rst),
        .clr     (fin),
        .wr_en   (a_wr),
        .wr_data (fifo_wr_data_a),
        .rd_idx  (rd_ptr),
        .rd_data (a_rd),
        .cnt     (a_cnt),
        .full    (a_full)
    );

    iddmm_word_buf #(.K(K), .N(N), .AW(ADDR_W)) u_buf_s (
        .clk     (clk),
        .rst     (rst),
        .clr     (fin),
        .wr_en   (s_wr),
        .wr_data (fifo_wr_data_sub),
        .rd_idx  (rd_ptr),
        .rd_data (s_rd),
        .cnt     (s_cnt),
        .full    (s_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDDMM_IDLE;
            rd_ptr    <= '0;
            sel       <= 1'b0;
            done_seen <= 1'b0;
        end else begin
            case (state)
                IDDMM_IDLE: begin
                    if (a_wr) state <= IDDMM_COLLECT;
                end
                IDDMM_COLLECT: begin
                    if (cal_done) done_seen <= 1'b1;
                    // Borrow is only valid alongside the final sub beat.
                    if (s_wr && s_cnt == (ADDR_W+1)'(N - 1))
                        sel <= cal_sign;
                    if (a_full && s_full && done_seen) begin
                        state  <= IDDMM_OUTPUT;
                        rd_ptr <= '0;
                    end
                end
                IDDMM_OUTPUT: begin
                    if (fin) begin
                        state     <= IDDMM_IDLE;
                        rd_ptr    <= '0;
                        sel       <= 1'b0;
                        done_seen <= 1'b0;
                    end else if (hs) begin
                        rd_ptr <= rd_ptr + 1'b1;
                    end
                end
                default: state <= IDDMM_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_err <= 1'b0;
        end else if (err_hit) begin
            o_err <= 1'b1;
        end
    end

    assign o_valid = in_out;
    assign o_busy  = !in_idle;
    assign o_data  = in_out ? (sel ? a_rd : s_rd) : '0;
    assign o_addr  = in_out ? rd_ptr : '0;
    assign o_last  = in_out && last_w;

endmodule

// File: tb/tb_iddmm_result_sel.sv
// Directed bench for iddmm_result_sel with a queue-based result model.
module tb_iddmm_result_sel;

    localparam int K  = 8;
    localparam int N  = 4;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_wr_en_a;
    logic [K-1:0]  fifo_wr_data_a;
    logic          fifo_wr_en_sub;
    logic [K-1:0]  fifo_wr_data_sub;
    logic          cal_done;
    logic          cal_sign;
    logic          o_valid;
    logic          o_ready;
    logic [K-1:0]  o_data;
    logic [AW-1:0] o_addr;
    logic          o_last;
    logic          o_busy;
    logic          o_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] out_log[$];
    int         out_idx = 0;

    iddmm_result_sel #(.K(K), .N(N), .ADDR_W(AW)) dut (
        .clk              (clk),
        .rst              (rst),
        .fifo_wr_en_a     (fifo_wr_en_a),
        .fifo_wr_data_a   (fifo_wr_data_a),
        .fifo_wr_en_sub   (fifo_wr_en_sub),
        .fifo_wr_data_sub (fifo_wr_data_sub),
        .cal_done         (cal_done),
        .cal_sign         (cal_sign),
        .o_valid          (o_valid),
        .o_ready          (o_ready),
        .o_data           (o_data),
        .o_addr           (o_addr),
        .o_last           (o_last),
        .o_busy           (o_busy),
        .o_err            (o_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Output stream must match the model queue word-for-word.
    always @(negedge clk) begin
        if (!rst && o_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 64'(o_valid), 64'd0);
            end else begin
                check("o_data", 64'(o_data), 64'(exp_q[0]));
                check("o_addr", 64'(o_addr), 64'(out_idx));
                check("o_last", 64'(o_last), 64'(out_idx == N - 1));
                if (o_ready) begin
                    out_log.push_back(o_data);
                    void'(exp_q.pop_front());
                    out_idx = (out_idx + 1) % N;
                end
            end
        end
    end

    function automatic logic [63:0] log_pack();
        logic [63:0] r = '0;
        for (int i = 0; i < out_log.size() && i < 8; i++)
            r[8*i +: 8] = out_log[i];
        return r;
    endfunction

    task automatic idle_inputs();
        fifo_wr_en_a     = 1'b0;
        fifo_wr_data_a   = '0;
        fifo_wr_en_sub   = 1'b0;
        fifo_wr_data_sub = '0;
        cal_done         = 1'b0;
        cal_sign         = 1'b0;
    endtask

    // A at cycles 0..n_a-1, sub two cycles behind, cal_done on 3rd sub.
    task automatic run_op(input logic [31:0] a_w, input logic [31:0] s_w,
                          input logic sign, input int n_a,
                          input logic [7:0] extra);
        for (int i = 0; i < N; i++)
            exp_q.push_back(sign ? a_w[8*i +: 8] : s_w[8*i +: 8]);
        for (int c = 0; c < 6; c++) begin
            fifo_wr_en_a   = (c < n_a);
            fifo_wr_data_a = (c < N) ? a_w[8*c +: 8] : extra;
            fifo_wr_en_sub = (c >= 2);
            fifo_wr_data_sub = (c >= 2) ? s_w[8*(c-2) +: 8] : 8'h00;
            cal_done = (c == 4);
            cal_sign = (c == 5) ? sign : 1'b0;
            @(posedge clk);
            #1;
        end
        idle_inputs();
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            n++;
            if (!o_busy && exp_q.size() == 0) return;
        end
        check("wait_idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        out_log.delete();
        out_idx = 0;
    endtask

    initial begin
        int n;
        logic [6:0] pat;
        rst = 1'b1;
        o_ready = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_err", 64'(o_err), 64'd0);
        check("rst_data", 64'(o_data), 64'd0);
        check("rst_last", 64'(o_last), 64'd0);
        rst = 1'b0;

        // Sign 1 selects A; also pins latency and busy fall.
        run_op(32'h44332211, 32'hA3A2A1A0, 1'b1, 4, 8'h00);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            n++;
            if (n == 1) check("lat_pre_valid", 64'(o_valid), 64'd0);
            if (n == 2) check("lat_first_valid", 64'(o_valid), 64'd1);
            if (!o_busy) break;
        end
        check("t1_busy_cycles", 64'(n), 64'd6);
        check("t1_count", 64'(out_log.size()), 64'd4);
        check("t1_words", log_pack(), 64'h44332211);
        check("t1_err", 64'(o_err), 64'd0);
        out_log.delete();

        // Sign 0 selects A-P.
        run_op(32'h44332211, 32'hA3A2A1A0, 1'b0, 4, 8'h00);
        wait_idle(n);
        check("t2_count", 64'(out_log.size()), 64'd4);
        check("t2_words", log_pack(), 64'hA3A2A1A0);
        out_log.delete();

        // Backpressure pattern 1,0,0,1,0,1,1 over the output cycles.
        o_ready = 1'b0;
        run_op(32'h04030201, 32'hE4E3E2E1, 1'b0, 4, 8'h00);
        @(posedge clk);
        #1;
        pat = 7'b1101001;
        for (int i = 0; i < 7; i++) begin
            o_ready = pat[i];
            @(posedge clk);
            #1;
        end
        o_ready = 1'b1;
        wait_idle(n);
        check("t3_count", 64'(out_log.size()), 64'd4);
        check("t3_words", log_pack(), 64'hE4E3E2E1);
        check("t3_busy", 64'(o_busy), 64'd0);
        out_log.delete();

        // Back-to-back: second stream starts right after o_last handshake.
        run_op(32'h13121110, 32'hB3B2B1B0, 1'b1, 4, 8'h00);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (o_valid && o_last && o_ready) break;
        end
        @(posedge clk);
        #1;
        check("t4_idle_gap", 64'(o_busy), 64'd0);
        run_op(32'h27262524, 32'hC7C6C5C4, 1'b0, 4, 8'h00);
        wait_idle(n);
        check("t4_count", 64'(out_log.size()), 64'd8);
        check("t4_words", log_pack(), 64'hC7C6C5C4_13121110);
        check("t4_err", 64'(o_err), 64'd0);
        out_log.delete();

        // Overflow A beat, then an A beat while outputting.
        run_op(32'h4D3C2B1A, 32'h9D8C7B6A, 1'b1, 5, 8'h55);
        check("t5_err_early", 64'(o_err), 64'd1);
        @(posedge clk);
        #1;
        fifo_wr_en_a   = 1'b1;
        fifo_wr_data_a = 8'h99;
        @(posedge clk);
        #1;
        idle_inputs();
        wait_idle(n);
        check("t5_err", 64'(o_err), 64'd1);
        check("t5_count", 64'(out_log.size()), 64'd4);
        check("t5_words", log_pack(), 64'h4D3C2B1A);
        out_log.delete();

        // Reset mid-collect, then a fresh full operation.
        for (int c = 0; c < 3; c++) begin
            fifo_wr_en_a     = (c < 2);
            fifo_wr_data_a   = 8'h21 + 8'(c);
            fifo_wr_en_sub   = (c == 2);
            fifo_wr_data_sub = 8'h81;
            @(posedge clk);
            #1;
        end
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t6_rst_valid", 64'(o_valid), 64'd0);
        check("t6_rst_busy", 64'(o_busy), 64'd0);
        check("t6_rst_err", 64'(o_err), 64'd0);
        check("t6_rst_data", 64'(o_data), 64'd0);
        check("t6_rst_addr", 64'(o_addr), 64'd0);
        rst = 1'b0;
        exp_q.delete();
        out_log.delete();
        out_idx = 0;
        run_op(32'h8899AABB, 32'h01020304, 1'b0, 4, 8'h00);
        wait_idle(n);
        check("t6_count", 64'(out_log.size()), 64'd4);
        check("t6_words", log_pack(), 64'h01020304);
        check("t6_err", 64'(o_err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
